// File: rtl/complex_alu.sv
// Complex add/sub/mul/conj-mul unit with valid/ready handshake and one shared multiplier.
// Define COMPLEX_ALU_SAT_EN to saturate result parts instead of wrapping.
module complex_alu #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] in1,
    input  logic [2*W-1:0] in2,
    input  logic [1:0]     op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out,
    output logic           ovf
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    localparam logic signed [2*W:0] MAXV = {{(W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W:0] MINV = {{(W+2){1'b1}}, {(W-1){1'b0}}};

    state_t state, state_nxt;
    logic [1:0] cnt;
    logic conj_q;
    logic signed [W-1:0] a_re, a_im, b_re, b_im, m_a, m_b;
    logic signed [2*W-1:0] prod;
    logic signed [2*W:0] pe, acc_re, acc_im, im_fin;
    logic [W:0] s_re, s_im;
    logic [W:0] n_re, n_im, q_re, q_im;
    logic accept;

    // Returns {out_of_range, narrowed_part}
    function automatic logic [W:0] narrow(input logic signed [2*W:0] v);
        logic hi, lo;
        logic [W-1:0] r;
        hi = v > MAXV;
        lo = v < MINV;
        r = v[W-1:0];
`ifdef COMPLEX_ALU_SAT_EN
        if (hi) r = MAXV[W-1:0];
        else if (lo) r = MINV[W-1:0];
`endif
        return {hi | lo, r};
    endfunction

    assign accept = in_valid && in_ready;

    always_comb begin
        s_re = {in1[2*W-1], in1[2*W-1:W]} + {in2[2*W-1], in2[2*W-1:W]};
        s_im = {in1[W-1], in1[W-1:0]} + {in2[W-1], in2[W-1:0]};
        if (op[0]) begin
            s_re = {in1[2*W-1], in1[2*W-1:W]} - {in2[2*W-1], in2[2*W-1:W]};
            s_im = {in1[W-1], in1[W-1:0]} - {in2[W-1], in2[W-1:0]};
        end
        n_re = narrow($signed({{W{s_re[W]}}, s_re}));
        n_im = narrow($signed({{W{s_im[W]}}, s_im}));
    end

    always_comb begin
        m_a = a_re;
        m_b = b_re;
        unique case (cnt)
            2'd0: begin m_a = a_re; m_b = b_re; end
            2'd1: begin m_a = a_im; m_b = b_im; end
            2'd2: begin m_a = a_re; m_b = b_im; end
            2'd3: begin m_a = a_im; m_b = b_re; end
        endcase
        prod = m_a * m_b;
        pe = {prod[2*W-1], prod};
        im_fin = acc_im + pe;
        q_re = narrow(acc_re);
        q_im = narrow(im_fin);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = op[1] ? MUL : DONE;
            end
            MUL: if (cnt == 2'd3) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_re <= '0;
            a_im <= '0;
            b_re <= '0;
            b_im <= '0;
            conj_q <= 1'b0;
            cnt <= '0;
            acc_re <= '0;
            acc_im <= '0;
            out <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            a_re <= in1[2*W-1:W];
            a_im <= in1[W-1:0];
            b_re <= in2[2*W-1:W];
            b_im <= in2[W-1:0];
            conj_q <= op[0];
            cnt <= '0;
            if (!op[1]) begin
                out <= {n_re[W-1:0], n_im[W-1:0]};
                ovf <= n_re[W] | n_im[W];
            end
        end else if (state == MUL) begin
            cnt <= cnt + 2'd1;
            // mul: re=p0-p1, im=p2+p3; conj-mul: re=p0+p1, im=p3-p2
            unique case (cnt)
                2'd0: acc_re <= pe;
                2'd1: acc_re <= conj_q ? acc_re + pe : acc_re - pe;
                2'd2: acc_im <= conj_q ? -pe : pe;
                2'd3: begin
                    acc_im <= im_fin;
                    out <= {q_re[W-1:0], q_im[W-1:0]};
                    ovf <= q_re[W] | q_im[W];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_complex_alu.sv
// Self-checking bench for complex_alu (W=4) against an integer reference model.
// Honours COMPLEX_ALU_SAT_EN the same way as the design.
module tb_complex_alu;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, ovf;
    logic [7:0] in1, in2, out;
    logic [1:0] op;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    complex_alu #(.W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .ovf(ovf)
    );

    function automatic logic [4:0] nar(input int v);
        logic [31:0] t;
        logic o;
        int x;
        x = v;
        o = (x > 7) || (x < -8);
`ifdef COMPLEX_ALU_SAT_EN
        if (x > 7) x = 7;
        else if (x < -8) x = -8;
`endif
        t = x;
        return {o, t[3:0]};
    endfunction

    // Returns {ovf, out} from exact complex arithmetic
    function automatic logic [8:0] model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        int ar, ai, br, bi, re, im;
        logic [4:0] nr, ni;
        ar = int'($signed(a[7:4]));
        ai = int'($signed(a[3:0]));
        br = int'($signed(b[7:4]));
        bi = int'($signed(b[3:0]));
        case (o)
            2'd0: begin re = ar + br; im = ai + bi; end
            2'd1: begin re = ar - br; im = ai - bi; end
            2'd2: begin re = ar*br - ai*bi; im = ar*bi + ai*br; end
            default: begin re = ar*br + ai*bi; im = ai*br - ar*bi; end
        endcase
        nr = nar(re);
        ni = nar(im);
        return {nr[4] | ni[4], nr[3:0], ni[3:0]};
    endfunction

    // Drives one transaction from IDLE, stalls the consumer, then takes the result
    task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          input int stall, output logic [7:0] r, output logic f, output int lat);
        in_valid = 1'b1;
        op = o;
        in1 = a;
        in2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in1 = 8'($urandom);
        in2 = 8'($urandom);
        op = 2'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        repeat (stall) begin @(posedge clk); #1; end
        r = out;
        f = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in1 = '0;
        in2 = '0;
        op = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out !== 8'h00) begin errors++; $display("FAIL reset_out got=%h exp=00", out); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_directed();
        logic [1:0] vo[6];
        logic [7:0] va[6], vb[6], vr[6];
        logic vf[6];
        logic [7:0] r;
        logic f;
        int lat;
        vo[0] = 2'd0; va[0] = 8'h11; vb[0] = 8'h01; vr[0] = 8'h12; vf[0] = 1'b0;
`ifdef COMPLEX_ALU_SAT_EN
        vo[1] = 2'd0; va[1] = 8'h37; vb[1] = 8'h81; vr[1] = 8'hB7; vf[1] = 1'b1;
`else
        vo[1] = 2'd0; va[1] = 8'h37; vb[1] = 8'h81; vr[1] = 8'hB8; vf[1] = 1'b1;
`endif
        vo[2] = 2'd1; va[2] = 8'hF5; vb[2] = 8'hE2; vr[2] = 8'h13; vf[2] = 1'b0;
        vo[3] = 2'd1; va[3] = 8'hFF; vb[3] = 8'h5A; vr[3] = 8'hA5; vf[3] = 1'b0;
        vo[4] = 2'd2; va[4] = 8'h12; vb[4] = 8'h3F; vr[4] = 8'h55; vf[4] = 1'b0;
        vo[5] = 2'd3; va[5] = 8'h12; vb[5] = 8'h11; vr[5] = 8'h31; vf[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_op(vo[i], va[i], vb[i], 0, r, f, lat);
            checks++;
            if (r !== vr[i]) begin errors++; $display("FAIL dir%0d_out got=%h exp=%h", i, r, vr[i]); end
            checks++;
            if (f !== vf[i]) begin errors++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, f, vf[i]); end
            checks++;
            if (lat != (vo[i][1] ? 5 : 1)) begin
                errors++;
                $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, vo[i][1] ? 5 : 1);
            end
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_after_take got out_valid=%b in_ready=%b exp 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] o;
        logic [7:0] a, b, r;
        logic [8:0] e;
        logic f;
        int lat;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = 8'($urandom);
            b = 8'($urandom);
            e = model(o, a, b);
            run_op(o, a, b, $urandom_range(0, 3), r, f, lat);
            checks++;
            if ({f, r} !== e) begin
                errors++;
                $display("FAIL rand%0d op=%0d a=%h b=%h got=%b/%h exp=%b/%h", i, o, a, b, f, r, e[8], e[7:0]);
            end
            checks++;
            if (lat != (o[1] ? 5 : 1)) begin
                errors++;
                $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, o[1] ? 5 : 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] e;
        int n, k;
        for (int ph = 0; ph < 2; ph++) begin
            op = (ph == 0) ? 2'd0 : 2'd2;
            in1 = 8'($urandom);
            in2 = 8'($urandom);
            e = model(op, in1, in2);
            in_valid = 1'b1;
            out_ready = 1'b1;
            n = 0;
            for (int c = 0; c < ((ph == 0) ? 20 : 30); c++) begin
                @(posedge clk); #1;
                if (out_valid === 1'b1) begin
                    n++;
                    checks++;
                    if ({ovf, out} !== e) begin
                        errors++;
                        $display("FAIL b2b%0d_data got=%b/%h exp=%b/%h", ph, ovf, out, e[8], e[7:0]);
                    end
                end
            end
            checks++;
            if (n != ((ph == 0) ? 10 : 5)) begin
                errors++;
                $display("FAIL b2b%0d_count got=%0d exp=%0d", ph, n, (ph == 0) ? 10 : 5);
            end
            in_valid = 1'b0;
            k = 0;
            while (in_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
            out_ready = 1'b0;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_drain got in_ready=%b exp=1", ph, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] a, b, r0;
        logic [8:0] e;
        logic f0;
        int k, n;
        a = 8'($urandom);
        b = 8'($urandom);
        e = model(2'd2, a, b);
        in_valid = 1'b1;
        op = 2'd2;
        in1 = a;
        in2 = b;
        @(posedge clk); #1;
        in1 = ~a;
        op = 2'd0;
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        r0 = out;
        f0 = ovf;
        checks++;
        if ({f0, r0} !== e) begin errors++; $display("FAIL bp_result got=%b/%h exp=%b/%h", f0, r0, e[8], e[7:0]); end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out !== r0 || ovf !== f0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got out=%h ovf=%b v=%b rdy=%b exp %h/%b/1/0",
                         c, out, ovf, out_valid, in_ready, r0, f0);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got v=%b rdy=%b exp 0/1", out_valid, in_ready);
        end
        n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL bp_extra_results got=%0d exp=0", n); end
    endtask

    task automatic test_reset_midop();
        logic [7:0] r;
        logic f;
        int lat, n;
        run_op(2'd0, 8'h11, 8'h01, 0, r, f, lat);
        in_valid = 1'b1;
        op = 2'd2;
        in1 = 8'h77;
        in2 = 8'h77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out !== 8'h00 || ovf !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_reset got v=%b out=%h ovf=%b rdy=%b exp 0/00/0/1", out_valid, out, ovf, in_ready);
        end
        out_ready = 1'b1;
        n = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) n++;
        end
        out_ready = 1'b0;
        checks++;
        if (n != 0) begin errors++; $display("FAIL midop_ghost_result got=%0d exp=0", n); end
        run_op(2'd3, 8'h12, 8'h11, 1, r, f, lat);
        checks++;
        if ({f, r} !== 9'h031) begin errors++; $display("FAIL midop_recover got=%b/%h exp=0/31", f, r); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
